// File: rtl/tt_um_seanvenadas.sv
// Single-digit seven-segment BCD counter with programmable prescaler, hold, direction and load.
// Build option: define COMMON_ANODE_EN to drive uo_out active-low (segments and dp inverted).
module tt_um_seanvenadas #(
  parameter int CLK_DIV_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [CLK_DIV_W-1:0] p_q, p_d;
  logic [3:0]           d_q, d_d;
  logic                 w_q, w_d;
  logic [CLK_DIV_W-1:0] cmp;
  logic                 load, hold, down, at_cmp, tick;
  logic [3:0]           load_val;
  logic [6:0]           seg;
  logic [7:0]           disp;
  logic                 unused_ok;

  assign load     = uio_in[4];
  assign hold     = uio_in[5];
  assign down     = uio_in[6];
  assign load_val = (uio_in[3:0] > 4'd9) ? 4'd9 : uio_in[3:0];

  // Rate select occupies the top 8 bits of the compare value; shifting keeps CLK_DIV_W=8 legal.
  assign cmp    = CLK_DIV_W'(ui_in) << (CLK_DIV_W - 8);
  assign at_cmp = (p_q >= cmp);
  assign tick   = at_cmp & ~load & ~hold & ~rst_n;

  always_comb begin
    p_d = p_q;
    d_d = d_q;
    w_d = w_q;
    if (load) begin
      d_d = load_val;
      p_d = '0;
    end else if (hold) begin
      p_d = p_q;
    end else if (at_cmp) begin
      p_d = '0;
      if (down) begin
        if (d_q == 4'd0) begin
          d_d = 4'd9;
          w_d = ~w_q;
        end else begin
          d_d = d_q - 4'd1;
        end
      end else begin
        if (d_q == 4'd9) begin
          d_d = 4'd0;
          w_d = ~w_q;
        end else begin
          d_d = d_q + 4'd1;
        end
      end
    end else begin
      p_d = p_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      p_q <= '0;
      d_q <= 4'd0;
      w_q <= 1'b0;
    end else begin
      p_q <= p_d;
      d_q <= d_d;
      w_q <= w_d;
    end
  end

  always_comb begin
    seg = 7'h00;
    case (d_q)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  assign disp = {w_q, seg};

`ifdef COMMON_ANODE_EN
  assign uo_out = ~disp;
`else
  assign uo_out = disp;
`endif

  assign uio_out = {tick, 7'b0};
  assign uio_oe  = 8'h80;

  // Slot enable and the spare bidirectional input have no function in this design.
  assign unused_ok = &{1'b0, ena, uio_in[7]};

endmodule

// File: tb/tb_tt_um_seanvenadas.sv
// Directed self-checking bench for the seven-segment counter: reset, up/down wrap, load clamp,
// hold freeze and the prescaler compare boundary at CLK_DIV_W=24, R=1.
module tb_tt_um_seanvenadas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

  tt_um_seanvenadas dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end else begin
      $display("ok   %s: %02h", tag, obs);
    end
  endtask

  // Display polarity follows the build option.
  function automatic logic [7:0] uo_exp(input logic [7:0] v);
`ifdef COMMON_ANODE_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] up_tbl [10];

  initial begin
    up_tbl = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'hBF};
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset
    clocks(2);
    chk("rst_uo", uo_out, uo_exp(8'h3F));
    chk("rst_oe", uio_oe, 8'h80);
    chk("rst_uio", uio_out, 8'h00);

    // Count up at R=0, one step per clock, wrap toggles dp
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clocks(1);
      chk($sformatf("up_%0d", i + 1), uo_out, uo_exp(up_tbl[i]));
    end
    chk("up_tick", uio_out, 8'h80);

    // Reset wins over a simultaneous load
    rst_n  = 1'b1;
    uio_in = 8'h15;
    clocks(1);
    chk("rst_over_load", uo_out, uo_exp(8'h3F));

    // Count down from 0 wraps to 9 and toggles dp
    uio_in = 8'h40;
    rst_n  = 1'b0;
    clocks(1);
    chk("down_1", uo_out, uo_exp(8'hEF));
    clocks(1);
    chk("down_2", uo_out, uo_exp(8'hFF));

    // Load clamp and load beating hold
    rst_n  = 1'b1;
    uio_in = 8'h00;
    clocks(1);
    rst_n  = 1'b0;
    uio_in = 8'h1C;
    clocks(1);
    chk("load_clamp", uo_out, uo_exp(8'h6F));
    uio_in = 8'h33;
    clocks(1);
    chk("load_hold", uo_out, uo_exp(8'h4F));
    chk("load_notick", uio_out, 8'h00);

    // Direction change takes effect on the next tick
    uio_in = 8'h00;
    clocks(1);
    chk("dir_up", uo_out, uo_exp(8'h66));
    uio_in = 8'h40;
    clocks(1);
    chk("dir_down", uo_out, uo_exp(8'h4F));

    // Rate R=1: compare value 65536, tick only when P reaches it
    uio_in = 8'h00;
    ui_in  = 8'h01;
    rst_n  = 1'b1;
    clocks(1);
    rst_n  = 1'b0;
    clocks(65535);
    chk("rate_pre_tick", uio_out, 8'h00);
    chk("rate_pre_uo", uo_out, uo_exp(8'h3F));
    clocks(1);
    chk("rate_tick", uio_out, 8'h80);
    chk("rate_tick_uo", uo_out, uo_exp(8'h3F));

    // Hold while the compare is met: tick masked, display frozen
    uio_in = 8'h20;
    #1;
    chk("hold_tick", uio_out, 8'h00);
    clocks(1000);
    chk("hold_uo", uo_out, uo_exp(8'h3F));
    chk("hold_tick2", uio_out, 8'h00);
    uio_in = 8'h00;
    #1;
    chk("release_tick", uio_out, 8'h80);
    clocks(1);
    chk("release_step", uo_out, uo_exp(8'h06));
    chk("release_ptr0", uio_out, 8'h00);

    // Lowering R below P ticks on the next edge
    clocks(100);
    chk("mid_uo", uo_out, uo_exp(8'h06));
    ui_in = 8'h00;
    #1;
    chk("lower_tick", uio_out, 8'h80);
    clocks(1);
    chk("lower_step", uo_out, uo_exp(8'h5B));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_seanvenadas.md
# tt_um_seanvenadas

Single-digit seven-segment decimal counter for the TinyTapeout user slot. A prescaler with a rate set by `ui_in` advances a BCD digit 0–9. The digit is decoded onto `uo_out[6:0]`, and a wrap-indicator toggles on `uo_out[7]`. Bidirectional pins provide hold, direction, parallel load and a tick monitor output.

## Interface
- `CLK_DIV_W`, default 24: prescaler width; must be ≥ 8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-high (asserted when 1); the harness-standard name is retained.
- `ena`  in  1  slot enable; ignored; the design always runs.
- `ui_in`  in  8  rate select R.
- `uio_in`  in  8  [3:0] load value, [4] load, [5] hold, [6] down, [7] unused.
- `uo_out`  out  8  [6:0] segments gfedcba (bit0 = a), [7] wrap toggle (dp).
- `uio_out`  out  8  [7] tick pulse, [6:0] = 0.
- `uio_oe`  out  8  constant 8'h80.

## Operation
- State:
  - prescaler P (CLK_DIV_W bits);
  - digit D (4 bits, always 0–9);
  - wrap flag W (1 bit).
- Compare value C = {R, (CLK_DIV_W-8) zero bits}.
- tick = (P ≥ C) & ~load & ~hold. This is combinational and is driven on uio_out[7].
- Per-edge priority, highest first:
  - reset: P←0, D←0, W←0.
  - load: D←min(uio_in[3:0], 9); P←0; W unchanged.
  - hold: P, D and W all frozen.
  - P ≥ C: P←0; D steps; W as below.
  - otherwise: P←P+1.
- Step, up (down=0): D←D+1. From 9 the step gives D←0 and W toggles.
- Step, down (down=1): D←D−1. From 0 the step gives D←9 and W toggles.
- Segment decode (combinational from D), 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- uo_out = {W, seg[6:0]}.
- Boundary rules:
  - If R is lowered so that C < P, the next edge ticks because the compare is ≥. P never wraps through 2^CLK_DIV_W.
  - With R=0, D steps every clock.
  - Changing `down` mid-count takes effect on the next tick. P is not disturbed.
  - Load values 10–15 clamp to 9.
  - Reset overrides load, hold and tick in the same cycle.

## Timing
- Reset values: uo_out=8'h3F, uio_out=8'h00, uio_oe=8'h80.
- Tick period = C+1 clocks. R=0 gives 1 clock; R=1 gives 65537 clocks at CLK_DIV_W=24.
- Latency:
  - D and W update on the edge where tick=1. uo_out reflects the new value immediately after that edge, with zero added cycles.
  - A load asserted in cycle n makes uo_out show the loaded digit after edge n.
  - P restarts from 0 after a load, so the first tick after the load comes C+1 clocks later.
- Releasing hold resumes counting from the frozen P, with no re-initialisation.

## Configuration
- Macro `COMMON_ANODE_EN`:
  - Defined: uo_out is bitwise inverted (segments and dp active-low). The reset value becomes 8'hC0.
  - Undefined: active-high outputs as specified above.
- uio_out and uio_oe are unaffected by the macro.

## Test plan
- Reset check: rst_n=1 for 2 clocks with ui_in=0 → uo_out=8'h3F, uio_oe=8'h80, uio_out=8'h00.
- Count up: release reset, ui_in=0, uio_in=0.
  - After 1 clock → uo_out=8'h06.
  - After 9 clocks → 8'h6F.
  - After 10 clocks → 8'hBF (D=0, W=1).
- Count down: from reset with uio_in[6]=1, ui_in=0, 1 clock → uo_out=8'hEF (D=9, W=1). 1 more clock → 8'hFF (D=8).
- Load clamp: uio_in=8'h1C for 1 clock → uo_out=8'h6F. Load also wins over a simultaneous hold (uio_in=8'h33 → 8'h4F).
- Hold and rate: ui_in=1, count 65536 clocks.
  - uio_out[7]=1 exactly at P=65536, then D increments.
  - With uio_in[5]=1 for 1000 clocks, uo_out and uio_out[7] are frozen.
- Macro build (`COMMON_ANODE_EN`): reset → uo_out=8'hC0; 1 clock with ui_in=0 → 8'hF9.
